// File: rtl/extract_unpacker.sv
`default_nettype none
// ============================================================================
//  Module   : extract_unpacker
//  Purpose  : Reassembles 16-bit extended instruction words from a byte
//             stream. Recovers the 6-bit immediate, the 8-bit address and the
//             control/beq mode flags, and presents them on a valid/ready port.
//             This module undoes the extender's field placement.
//  Ports    : clk, rst_n (async, active-low)
//             in_valid/in_ready/in_byte   - byte input handshake
//             in_control/in_beq           - mode flags, taken with first byte
//             out_valid/out_ready         - field output handshake
//             out_imm/out_addr            - recovered fields
//             out_control/out_beq         - latched mode flags
//             fmt_err                     - only with UNPACK_CHECK_EN defined
//  Params   : HI_FIRST - 1: first byte is word[15:8]; 0: first is word[7:0]
//  Macro    : UNPACK_CHECK_EN - adds fmt_err (nonzero bits outside field)
//  Revision : 1.0 - initial release
// ============================================================================
module extract_unpacker #(
   parameter bit HI_FIRST = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_byte,
   input  logic       in_control,
   input  logic       in_beq,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [5:0] out_imm,
   output logic [7:0] out_addr,
   output logic       out_control,
   output logic       out_beq
`ifdef UNPACK_CHECK_EN
   ,
   output logic       fmt_err
`endif
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HALF  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t      state;
   logic [7:0]  half_byte;     // first byte of the word being assembled
   logic        mode_control;  // flags latched with the first byte
   logic        mode_beq;
   logic [15:0] full_word;
   logic [5:0]  rec_imm;
   logic [7:0]  rec_addr;
   logic        accept;

   // In FULL a new byte can only enter when the pending word drains this cycle.
   assign in_ready = (state != FULL) || out_ready;
   assign accept   = in_valid && in_ready;

   // Word as it will look once the byte on in_byte completes it.
   assign full_word = HI_FIRST ? {half_byte, in_byte} : {in_byte, half_byte};

   // Field recovery; control mode takes priority over beq mode.
   always_comb begin
      rec_imm  = '0;
      rec_addr = '0;
      if (mode_control) begin
         rec_imm = full_word[15:10];
      end else if (mode_beq) begin
         rec_addr = full_word[15:8];
      end else begin
         rec_imm = full_word[7:2];
      end
   end

`ifdef UNPACK_CHECK_EN
   logic rec_err;

   // Any set bit outside the recovered field flags a malformed word.
   always_comb begin
      rec_err = 1'b0;
      if (mode_control) begin
         rec_err = |full_word[9:0];
      end else if (mode_beq) begin
         rec_err = |full_word[7:0];
      end else begin
         rec_err = (|full_word[15:8]) || (|full_word[1:0]);
      end
   end
`else
   // The two lowest bits only matter to the format check.
   logic unused_low_bits;
   assign unused_low_bits = ^full_word[1:0];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= EMPTY;
         half_byte    <= '0;
         mode_control <= 1'b0;
         mode_beq     <= 1'b0;
         out_valid    <= 1'b0;
         out_imm      <= '0;
         out_addr     <= '0;
         out_control  <= 1'b0;
         out_beq      <= 1'b0;
`ifdef UNPACK_CHECK_EN
         fmt_err      <= 1'b0;
`endif
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  half_byte    <= in_byte;
                  mode_control <= in_control;
                  mode_beq     <= in_beq;
                  state        <= HALF;
               end
            end
            HALF: begin
               if (accept) begin
                  out_imm     <= rec_imm;
                  out_addr    <= rec_addr;
                  out_control <= mode_control;
                  out_beq     <= mode_beq;
                  out_valid   <= 1'b1;
`ifdef UNPACK_CHECK_EN
                  fmt_err     <= rec_err;
`endif
                  state       <= FULL;
               end
            end
            FULL: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
`ifdef UNPACK_CHECK_EN
                  fmt_err   <= 1'b0;
`endif
                  // Drain and next fill overlap so back-to-back words have
                  // no bubble.
                  if (accept) begin
                     half_byte    <= in_byte;
                     mode_control <= in_control;
                     mode_beq     <= in_beq;
                     state        <= HALF;
                  end else begin
                     state <= EMPTY;
                  end
               end
            end
            default: begin
               state <= EMPTY;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_extract_unpacker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_extract_unpacker
//  Purpose  : Self-checking bench for extract_unpacker (HI_FIRST = 1).
//             Table vectors, hand-written throughput/stall/reset sequences
//             and a randomized run against a word-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_extract_unpacker;
   localparam bit HI_FIRST = 1'b1;
   localparam int NW       = 150;
   localparam int BUDGET   = 8000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_byte = 8'h00;
   logic       in_control = 1'b0;
   logic       in_beq = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [5:0] out_imm;
   logic [7:0] out_addr;
   logic       out_control;
   logic       out_beq;
`ifdef UNPACK_CHECK_EN
   logic       fmt_err;
`endif

   int checks = 0;
   int errors = 0;

   extract_unpacker #(.HI_FIRST(HI_FIRST)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_byte    (in_byte),
      .in_control (in_control),
      .in_beq     (in_beq),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_imm    (out_imm),
      .out_addr   (out_addr),
      .out_control(out_control),
      .out_beq    (out_beq)
`ifdef UNPACK_CHECK_EN
      ,
      .fmt_err    (fmt_err)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1);
   end

   typedef struct {
      logic [7:0] b0;
      logic [7:0] b1;
      logic       c;
      logic       bq;
      logic [5:0] imm;
      logic [7:0] addr;
      logic       err;
   } vec_t;

   typedef struct {
      logic [5:0] imm;
      logic [7:0] addr;
      logic       c;
      logic       bq;
      logic       err;
   } exp_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_fields(input string name, input exp_t e);
      check({name, "_valid"}, {31'd0, out_valid}, 32'd1);
      check({name, "_imm"}, {26'd0, out_imm}, {26'd0, e.imm});
      check({name, "_addr"}, {24'd0, out_addr}, {24'd0, e.addr});
      check({name, "_control"}, {31'd0, out_control}, {31'd0, e.c});
      check({name, "_beq"}, {31'd0, out_beq}, {31'd0, e.bq});
`ifdef UNPACK_CHECK_EN
      check({name, "_fmt_err"}, {31'd0, fmt_err}, {31'd0, e.err});
`endif
   endtask

   // Reference model: whole-word arithmetic on the two bytes in arrival order.
   function automatic exp_t model(input logic [7:0] b0, input logic [7:0] b1,
                                  input logic c, input logic bq);
      exp_t e;
      int   w;
      w = HI_FIRST ? (int'(b0) * 256 + int'(b1)) : (int'(b1) * 256 + int'(b0));
      e.c  = c;
      e.bq = bq;
      if (c) begin
         e.imm  = 6'(w / 1024);
         e.addr = 8'd0;
         e.err  = (w % 1024) != 0;
      end else if (bq) begin
         e.imm  = 6'd0;
         e.addr = 8'(w / 256);
         e.err  = (w % 256) != 0;
      end else begin
         e.imm  = 6'((w / 4) % 64);
         e.addr = 8'd0;
         e.err  = ((w / 256) != 0) || ((w % 4) != 0);
      end
      return e;
   endfunction

   task automatic drive(input logic v, input logic [7:0] b, input logic c, input logic bq);
      @(negedge clk);
      in_valid   = v;
      in_byte    = b;
      in_control = c;
      in_beq     = bq;
   endtask

   vec_t vecs[8];

   initial begin
      exp_t e;
      exp_t expq[$];
      int   bad, bad_rdy, nw, bi, received, cyc;
      logic [7:0] cur_b0;
      logic cur_c, cur_bq;

      //               b0     b1     c     bq    imm    addr   err
      vecs[0] = '{8'hA8, 8'h00, 1'b1, 1'b0, 6'h2A, 8'h00, 1'b0};
      vecs[1] = '{8'h5C, 8'h00, 1'b0, 1'b1, 6'h00, 8'h5C, 1'b0};
      vecs[2] = '{8'h00, 8'h7C, 1'b0, 1'b0, 6'h1F, 8'h00, 1'b0};
      vecs[3] = '{8'hA8, 8'h01, 1'b1, 1'b0, 6'h2A, 8'h00, 1'b1};
      vecs[4] = '{8'hFF, 8'hFF, 1'b1, 1'b1, 6'h3F, 8'h00, 1'b1};
      vecs[5] = '{8'h12, 8'h34, 1'b0, 1'b1, 6'h00, 8'h12, 1'b1};
      vecs[6] = '{8'h01, 8'h7C, 1'b0, 1'b0, 6'h1F, 8'h00, 1'b1};
      vecs[7] = '{8'h00, 8'hFE, 1'b0, 1'b0, 6'h3F, 8'h00, 1'b1};

      // ---------------- reset state ----------------
      repeat (3) @(negedge clk);
      #1;
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_imm", {26'd0, out_imm}, 32'd0);
      check("rst_addr", {24'd0, out_addr}, 32'd0);
      check("rst_ctrl_beq", {30'd0, out_control, out_beq}, 32'd0);
`ifdef UNPACK_CHECK_EN
      check("rst_fmt_err", {31'd0, fmt_err}, 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      // ---------------- table vectors ----------------
      for (int i = 0; i < 8; i++) begin
         out_ready = 1'b0;
         drive(1'b1, vecs[i].b0, vecs[i].c, vecs[i].bq);
         // Flags on the second byte are inverted to show they are ignored.
         drive(1'b1, vecs[i].b1, ~vecs[i].c, ~vecs[i].bq);
         #1;
         check("tbl_latency_early", {31'd0, out_valid}, 32'd0);
         drive(1'b0, 8'h00, 1'b0, 1'b0);
         #1;
         e = '{vecs[i].imm, vecs[i].addr, vecs[i].c, vecs[i].bq, vecs[i].err};
         check_fields($sformatf("tbl%0d", i), e);
         @(negedge clk);
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
         #1;
         check("tbl_drained", {31'd0, out_valid}, 32'd0);
`ifdef UNPACK_CHECK_EN
         check("tbl_fmt_err_clear", {31'd0, fmt_err}, 32'd0);
`endif
      end

      // ---------------- back-to-back throughput ----------------
      bad = 0; bad_rdy = 0; nw = 0;
      for (int n = 0; n < 18; n++) begin
         @(negedge clk);
         out_ready  = 1'b1;
         in_control = 1'b0;
         in_beq     = 1'b1;
         in_valid   = (n < 16);
         in_byte    = (n % 2 == 0) ? 8'(8'h10 + n) : 8'h00;
         #1;
         if (out_valid !== ((n >= 2) && (n <= 16) && (n % 2 == 0))) bad++;
         if ((n < 16) && (in_ready !== 1'b1)) bad_rdy++;
         if (out_valid === 1'b1) begin
            check("tput_addr", {24'd0, out_addr}, 32'(8'h10 + 2 * nw));
            nw++;
         end
      end
      in_valid = 1'b0;
      check("tput_pattern", bad, 0);
      check("tput_in_ready", bad_rdy, 0);
      check("tput_words", nw, 8);

      // ---------------- stall in FULL ----------------
      out_ready = 1'b0;
      drive(1'b1, 8'hA8, 1'b1, 1'b0);
      drive(1'b1, 8'h00, 1'b0, 1'b0);
      bad = 0;
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, 8'h00, 1'b0, 1'b0);
         out_ready = 1'b0;
         #1;
         if (!(out_valid === 1'b1 && in_ready === 1'b0 && out_imm === 6'h2A &&
               out_addr === 8'h00 && out_control === 1'b1)) bad++;
      end
      check("stall_hold", bad, 0);
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      check("stall_release_ready", {31'd0, in_ready}, 32'd1);
      drive(1'b1, 8'h7C, 1'b1, 1'b1);
      out_ready = 1'b0;
      #1;
      check("stall_drained", {31'd0, out_valid}, 32'd0);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      #1;
      check_fields("stall_next", model(8'h00, 8'h7C, 1'b0, 1'b0));
      @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);

      // ---------------- reset mid-word (HALF) ----------------
      drive(1'b1, 8'hFF, 1'b1, 1'b1);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      check("rsth_valid", {31'd0, out_valid}, 32'd0);
      check("rsth_outs", {16'd0, out_imm, out_addr, out_control, out_beq}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b0;
      drive(1'b1, 8'h00, 1'b0, 1'b0);
      drive(1'b1, 8'h04, 1'b0, 1'b0);
      #1;
      check("rsth_no_early", {31'd0, out_valid}, 32'd0);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      #1;
      check_fields("rsth_next", '{6'h01, 8'h00, 1'b0, 1'b0, 1'b0});

      // ---------------- reset in FULL ----------------
      rst_n = 1'b0;
      #1;
      check("rstf_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      bad = 0;
      repeat (3) begin
         @(negedge clk);
         #1;
         if (out_valid !== 1'b0) bad++;
      end
      check("rstf_nothing_emitted", bad, 0);

      // ---------------- randomized run against the model ----------------
      bi = 0; received = 0; cyc = 0;
      while (received < NW && cyc < BUDGET) begin
         @(negedge clk);
         cyc++;
         out_ready  = ($urandom_range(0, 3) != 0);
         in_valid   = (bi < 2 * NW) && ($urandom_range(0, 3) != 0);
         in_byte    = 8'($urandom);
         in_control = 1'($urandom);
         in_beq     = 1'($urandom);
         #1;
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (expq.size() == 0) begin
               check("rnd_spurious_word", 32'd1, 32'd0);
            end else begin
               e = expq.pop_front();
               check_fields("rnd", e);
            end
            received++;
         end
         if (in_valid === 1'b1 && in_ready === 1'b1) begin
            if (bi % 2 == 0) begin
               cur_b0 = in_byte;
               cur_c  = in_control;
               cur_bq = in_beq;
            end else begin
               expq.push_back(model(cur_b0, in_byte, cur_c, cur_bq));
            end
            bi++;
         end
      end
      in_valid = 1'b0;
      check("rnd_words_received", received, NW);
      check("rnd_queue_empty", expq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
